// File: rtl/cfg_bank_pkg.sv
// Shared types and elaboration helpers for the configuration-bank bl/wl sequencer.
package cfg_bank_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_DONE
  } state_t;

  // Phase down-counter width: wide enough for the longest phase count.
  function automatic int cnt_width(input int setup_cyc, input int pulse_cyc, input int hold_cyc);
    int m;
    m = setup_cyc;
    if (pulse_cyc > m) m = pulse_cyc;
    if (hold_cyc > m) m = hold_cyc;
    return $clog2(m) + 1;
  endfunction

  function automatic bit params_legal(input int setup_cyc, input int pulse_cyc, input int hold_cyc);
    return (setup_cyc >= 1) && (pulse_cyc >= 1) && (hold_cyc >= 1);
  endfunction

endpackage

// File: rtl/cfg_bank_bl_wl_sequencer_if.sv
// Upstream configuration-word stream (valid/ready) into the bl/wl sequencer.
interface cfg_bank_bl_wl_sequencer_if #(
  parameter int NUM_BL = 8,
  parameter int ADDR_W = 3
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [NUM_BL-1:0] cfg_bl;
  logic [ADDR_W-1:0] cfg_wl_addr;
  logic              cfg_last;

  modport master (output cfg_valid, cfg_bl, cfg_wl_addr, cfg_last, input cfg_ready);
  modport slave  (input cfg_valid, cfg_bl, cfg_wl_addr, cfg_last, output cfg_ready);
endinterface

// File: rtl/wl_onehot_decoder.sv
// Row address to one-hot wordline vector; all zero when disabled or out of range.
module wl_onehot_decoder #(
  parameter int NUM_WL = 8,
  parameter int ADDR_W = 3
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              en,
  output logic [NUM_WL-1:0] wl
);

  always_comb begin
    wl = '0;
    for (int i = 0; i < NUM_WL; i++) begin
      if (en && (addr == ADDR_W'(i))) wl[i] = 1'b1;
    end
  end

endmodule

// File: rtl/cfg_bank_bl_wl_sequencer.sv
// Drives a configuration row onto the bitlines, then pulses one wordline with
// setup/hold margins so the tile SRAM cells latch it.
//
// state | meaning
// IDLE  | waiting for a word, cfg_ready=1
// SETUP | bl driven, wl low, bl settling before the pulse
// PULSE | bl driven, addressed wl high
// HOLD  | bl driven, wl low, cells release before bl changes
// DONE  | last word written; accepts a new stream like IDLE
module cfg_bank_bl_wl_sequencer
  import cfg_bank_pkg::*;
#(
  parameter int NUM_BL    = 8,
  parameter int NUM_WL    = 8,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1,
  parameter int ADDR_W    = (NUM_WL > 1) ? $clog2(NUM_WL) : 1
) (
  input  logic                      prog_clk,
  input  logic                      pReset,
  cfg_bank_bl_wl_sequencer_if.slave cfg,
  output logic [NUM_BL-1:0]         bl,
  output logic [NUM_WL-1:0]         wl,
  output logic                      cfg_busy,
  output logic                      cfg_done,
  output logic                      cfg_err
);

  localparam int CNT_W = cnt_width(SETUP_CYC, PULSE_CYC, HOLD_CYC);
  localparam logic [ADDR_W:0] NUM_WL_V = (ADDR_W + 1)'(NUM_WL);

  if (!params_legal(SETUP_CYC, PULSE_CYC, HOLD_CYC)) begin : g_bad_params
    $error("cfg_bank_bl_wl_sequencer: SETUP_CYC, PULSE_CYC and HOLD_CYC must all be >= 1");
  end

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [ADDR_W-1:0]  row, row_n;
  logic               last_q, last_n;
  logic [NUM_BL-1:0]  bl_n;
  logic               done_n, err_n;
  logic               ready_q;
  logic               accept, addr_ok;
  logic [NUM_WL-1:0]  wl_dec;

  assign cfg.cfg_ready = ready_q;
  assign accept  = cfg.cfg_valid && ready_q;
  assign addr_ok = {1'b0, cfg.cfg_wl_addr} < NUM_WL_V;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    row_n   = row;
    last_n  = last_q;
    bl_n    = bl;
    done_n  = cfg_done;
    err_n   = cfg_err;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          if (addr_ok) begin
            bl_n    = cfg.cfg_bl;
            row_n   = cfg.cfg_wl_addr;
            last_n  = cfg.cfg_last;
            done_n  = 1'b0;
            state_n = ST_SETUP;
            cnt_n   = CNT_W'(SETUP_CYC - 1);
          end else begin
            // Bad row: word is dropped, but a trailing last still closes the stream.
            err_n = 1'b1;
            if (cfg.cfg_last) begin
              state_n = ST_DONE;
              done_n  = 1'b1;
            end
          end
        end
      end
      ST_SETUP: begin
        if (cnt == '0) begin
          state_n = ST_PULSE;
          cnt_n   = CNT_W'(PULSE_CYC - 1);
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      ST_PULSE: begin
        if (cnt == '0) begin
          state_n = ST_HOLD;
          cnt_n   = CNT_W'(HOLD_CYC - 1);
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt == '0) begin
          bl_n    = '0;
          state_n = last_q ? ST_DONE : ST_IDLE;
          done_n  = last_q;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Decoding the next-state row keeps wl registered and aligned with the phase.
  wl_onehot_decoder #(.NUM_WL(NUM_WL), .ADDR_W(ADDR_W)) u_dec (
    .addr (row_n),
    .en   (state_n == ST_PULSE),
    .wl   (wl_dec)
  );

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      row      <= '0;
      last_q   <= 1'b0;
      bl       <= '0;
      wl       <= '0;
      cfg_busy <= 1'b0;
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      row      <= row_n;
      last_q   <= last_n;
      bl       <= bl_n;
      wl       <= wl_dec;
      cfg_busy <= (state_n == ST_SETUP) || (state_n == ST_PULSE) || (state_n == ST_HOLD);
      cfg_done <= done_n;
      cfg_err  <= err_n;
      ready_q  <= (state_n == ST_IDLE) || (state_n == ST_DONE);
    end
  end

endmodule

// File: tb/tb_cfg_bank_bl_wl_sequencer.sv
// Self-checking bench: a word-timeline reference model (cycles since accept)
// for the default instance, plus a 6-row instance for out-of-range addresses.
module tb_cfg_bank_bl_wl_sequencer;

  localparam int S = 1, PW = 2, H = 1;
  localparam int PERIOD = 1 + S + PW + H;

  logic prog_clk = 1'b0;
  logic pReset;
  always #5 prog_clk = ~prog_clk;

  cfg_bank_bl_wl_sequencer_if #(.NUM_BL(8), .ADDR_W(3)) c ();
  cfg_bank_bl_wl_sequencer_if #(.NUM_BL(8), .ADDR_W(3)) c6 ();

  logic [7:0] bl, wl;
  logic       busy, done, err;
  logic [7:0] bl6;
  logic [5:0] wl6;
  logic       busy6, done6, err6;

  cfg_bank_bl_wl_sequencer dut (
    .prog_clk (prog_clk), .pReset (pReset), .cfg (c),
    .bl (bl), .wl (wl), .cfg_busy (busy), .cfg_done (done), .cfg_err (err)
  );

  cfg_bank_bl_wl_sequencer #(.NUM_WL(6)) dut6 (
    .prog_clk (prog_clk), .pReset (pReset), .cfg (c6),
    .bl (bl6), .wl (wl6), .cfg_busy (busy6), .cfg_done (done6), .cfg_err (err6)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: age = cycles since the accept edge (0 = no word in flight).
  int         age;
  logic [7:0] m_bl;
  int         m_row;
  bit         m_last, m_done, m_err;

  logic [19:0] obs;
  assign obs = {bl, wl, busy, c.cfg_ready, done, err};

  function automatic logic [19:0] exp_vec();
    logic [7:0] eb, ew;
    eb = (age != 0) ? m_bl : 8'h00;
    ew = (age >= 1 + S && age <= S + PW) ? 8'(1 << m_row) : 8'h00;
    return {eb, ew, age != 0, age == 0, m_done, m_err};
  endfunction

  task automatic model_reset();
    age = 0; m_bl = '0; m_row = 0; m_last = 0; m_done = 0; m_err = 0;
  endtask

  task automatic drive(input bit v, input logic [7:0] b, input int a, input bit l);
    c.cfg_valid = v; c.cfg_bl = b; c.cfg_wl_addr = 3'(a); c.cfg_last = l;
  endtask

  task automatic tick(output bit acc);
    logic [7:0] vb;
    logic [2:0] va;
    logic       vl;
    acc = c.cfg_valid && (age == 0);
    vb = c.cfg_bl; va = c.cfg_wl_addr; vl = c.cfg_last;
    @(posedge prog_clk);
    if (age != 0) begin
      age++;
      if (age == PERIOD) begin
        age = 0;
        if (m_last) m_done = 1;
      end
    end else if (acc) begin
      age = 1; m_bl = vb; m_row = int'(va); m_last = vl; m_done = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    bit acc;
    pReset = 1'b1;
    drive(0, 8'h00, 0, 0);
    c6.cfg_valid = 0; c6.cfg_bl = '0; c6.cfg_wl_addr = '0; c6.cfg_last = 0;
    model_reset();
    #12;
    checks++;
    if (obs !== 20'h0) begin errors++; $display("FAIL reset_state got %h exp %h", obs, 20'h0); end
    checks++;
    if ({bl6, wl6, busy6, c6.cfg_ready, done6, err6} !== 18'h0) begin
      errors++; $display("FAIL reset_state6 got %h exp 0", {bl6, wl6, busy6, c6.cfg_ready, done6, err6});
    end
    @(negedge prog_clk); pReset = 1'b0; #1;
    checks++;
    if (c.cfg_ready !== 1'b0) begin errors++; $display("FAIL ready_before_edge got %b exp 0", c.cfg_ready); end
    @(posedge prog_clk); #1;
    checks++;
    if (obs !== exp_vec()) begin errors++; $display("FAIL ready_after_release got %h exp %h", obs, exp_vec()); end
    // word in flight, then reset mid-PULSE
    drive(1, 8'hA5, 3, 1);
    tick(acc);
    drive(0, 8'h00, 0, 0);
    tick(acc);
    checks++;
    if ({bl, wl} !== {8'hA5, 8'h08}) begin errors++; $display("FAIL pulse_before_reset got %h exp %h", {bl, wl}, {8'hA5, 8'h08}); end
    #3 pReset = 1'b1; #1;
    model_reset();
    checks++;
    if (obs !== 20'h0) begin errors++; $display("FAIL async_reset_clear got %h exp %h", obs, 20'h0); end
    @(negedge prog_clk); pReset = 1'b0; #1;
    checks++;
    if (c.cfg_ready !== 1'b0) begin errors++; $display("FAIL ready_before_edge2 got %b exp 0", c.cfg_ready); end
    @(posedge prog_clk); #1;
    checks++;
    if (obs !== exp_vec() || c.cfg_ready !== 1'b1) begin
      errors++; $display("FAIL ready_after_release2 got %h exp %h", obs, exp_vec());
    end
  endtask

  task automatic test_single();
    bit acc;
    logic [7:0] eb, ew;
    drive(1, 8'h3C, 2, 1);
    tick(acc);
    drive(0, 8'h00, 0, 0);
    for (int k = 1; k <= PERIOD; k++) begin
      if (k > 1) tick(acc);
      eb = (k <= 4) ? 8'h3C : 8'h00;
      ew = (k == 2 || k == 3) ? 8'h04 : 8'h00;
      checks++;
      if ({bl, wl} !== {eb, ew}) begin errors++; $display("FAIL single_blwl k=%0d got %h exp %h", k, {bl, wl}, {eb, ew}); end
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL single_model k=%0d got %h exp %h", k, obs, exp_vec()); end
    end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL single_done got %b exp 1", done); end
  endtask

  task automatic test_back_to_back();
    int rows [3] = '{0, 1, 7};
    logic [7:0] wb [3];
    int edges [3];
    int n, idx;
    bit acc;
    logic [7:0] prev_bl;
    for (int i = 0; i < 3; i++) wb[i] = 8'($urandom);
    n = 0; idx = 0;
    drive(1, wb[0], rows[0], 0);
    for (int cyc = 0; cyc < 20; cyc++) begin
      prev_bl = bl;
      tick(acc);
      if (acc) begin
        edges[n] = cyc; n++; idx++;
        if (idx < 3) drive(1, wb[idx], rows[idx], 0);
        else drive(0, 8'h00, 0, 0);
      end
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL b2b_model cyc=%0d got %h exp %h", cyc, obs, exp_vec()); end
      checks++;
      if ((bl !== prev_bl) && (wl !== 8'h00)) begin errors++; $display("FAIL b2b_wl_during_bl_change cyc=%0d wl %h exp 00", cyc, wl); end
      checks++;
      if ($countones(wl) > 1) begin errors++; $display("FAIL b2b_onehot cyc=%0d wl %h exp at most one bit", cyc, wl); end
    end
    checks++;
    if (n !== 3) begin
      errors++; $display("FAIL b2b_accept_count got %0d exp 3", n);
    end else begin
      checks++;
      if (edges[0] != 0 || edges[1] != 5 || edges[2] != 10) begin
        errors++; $display("FAIL b2b_accept_edges got %0d %0d %0d exp 0 5 10", edges[0], edges[1], edges[2]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit acc;
    logic [7:0] w;
    w = 8'($urandom);
    drive(1, w, 5, 0);
    tick(acc);
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if ({c.cfg_ready, bl} !== {1'b0, w}) begin errors++; $display("FAIL bp_hold k=%0d got %h exp %h", k, {c.cfg_ready, bl}, {1'b0, w}); end
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL bp_model k=%0d got %h exp %h", k, obs, exp_vec()); end
      drive(k[0], 8'($urandom), $urandom_range(0, 7), $urandom_range(0, 1) == 1);
      tick(acc);
    end
    drive(0, 8'h00, 0, 0);
    checks++;
    if (obs !== exp_vec()) begin errors++; $display("FAIL bp_after got %h exp %h", obs, exp_vec()); end
  endtask

  task automatic test_random();
    bit acc;
    for (int i = 0; i < 300; i++) begin
      if (!(c.cfg_valid && age != 0))
        drive($urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 7), $urandom_range(0, 5) == 0);
      tick(acc);
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL random i=%0d got %h exp %h", i, obs, exp_vec()); end
    end
    drive(0, 8'h00, 0, 0);
    repeat (PERIOD) tick(acc);
  endtask

  task automatic test_restart();
    bit acc;
    logic [7:0] ew;
    drive(1, 8'($urandom), 6, 1);
    tick(acc);
    drive(0, 8'h00, 0, 0);
    repeat (4) tick(acc);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL restart_first_done got %b exp 1", done); end
    drive(1, 8'($urandom), 4, 1);
    tick(acc);
    drive(0, 8'h00, 0, 0);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL restart_done_clear got %b exp 0", done); end
    for (int k = 2; k <= PERIOD; k++) begin
      tick(acc);
      ew = (k <= 3) ? 8'h10 : 8'h00;
      checks++;
      if ({done, wl} !== {k == PERIOD, ew}) begin
        errors++; $display("FAIL restart k=%0d got %h exp %h", k, {done, wl}, {k == PERIOD, ew});
      end
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL restart_model k=%0d got %h exp %h", k, obs, exp_vec()); end
    end
  endtask

  task automatic test_error();
    logic [7:0] d;
    logic [7:0] eb;
    logic [5:0] ew;
    c6.cfg_valid = 1; c6.cfg_bl = 8'hFF; c6.cfg_wl_addr = 3'd7; c6.cfg_last = 0;
    @(posedge prog_clk); #1;
    c6.cfg_valid = 0;
    checks++;
    if ({err6, wl6, bl6, c6.cfg_ready, busy6, done6} !== {1'b1, 6'h00, 8'h00, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL err_drop got %h exp %h", {err6, wl6, bl6, c6.cfg_ready, busy6, done6}, {1'b1, 6'h00, 8'h00, 1'b1, 1'b0, 1'b0});
    end
    d = 8'($urandom);
    c6.cfg_valid = 1; c6.cfg_bl = d; c6.cfg_wl_addr = 3'd5; c6.cfg_last = 0;
    @(posedge prog_clk); #1;
    c6.cfg_valid = 0;
    for (int k = 1; k <= PERIOD; k++) begin
      if (k > 1) begin @(posedge prog_clk); #1; end
      eb = (k < PERIOD) ? d : 8'h00;
      ew = (k == 2 || k == 3) ? 6'b100000 : 6'b000000;
      checks++;
      if ({bl6, wl6, err6, c6.cfg_ready} !== {eb, ew, 1'b1, k == PERIOD}) begin
        errors++; $display("FAIL err_row5 k=%0d got %h exp %h", k, {bl6, wl6, err6, c6.cfg_ready}, {eb, ew, 1'b1, k == PERIOD});
      end
    end
    c6.cfg_valid = 1; c6.cfg_bl = 8'h5A; c6.cfg_wl_addr = 3'd6; c6.cfg_last = 1;
    @(posedge prog_clk); #1;
    c6.cfg_valid = 0;
    checks++;
    if ({done6, err6, c6.cfg_ready, wl6, bl6} !== {1'b1, 1'b1, 1'b1, 6'h00, 8'h00}) begin
      errors++; $display("FAIL err_last_drop got %h exp %h", {done6, err6, c6.cfg_ready, wl6, bl6}, {1'b1, 1'b1, 1'b1, 6'h00, 8'h00});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_restart();
    test_error();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
